// File: rtl/cond_counter_p_if.sv
// Bus bundle for cond_counter_p: operation request (en/S/datain) towards the counter
// and the registered counter status back out.
interface cond_counter_p_if #(
  parameter int WIDTH = 8
);
  // Handshake: en acts as the valid qualifier for S/datain. The counter is always ready,
  // so every cycle with en=1 at a rising clk edge is one accepted operation.
  logic             en;
  logic [1:0]       S;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             tc;
  logic             bflag;
  logic             dir;

  modport master (
    output en, S, datain,
    input  dataout, tc, bflag, dir
  );

  modport slave (
    input  en, S, datain,
    output dataout, tc, bflag, dir
  );
endinterface

// File: rtl/cond_counter_p.sv
// Parametrised conditional up/down counter with wrap or saturate boundary handling,
// terminal-count pulse, sticky boundary flag and last-direction output.
module cond_counter_p #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input logic             clk,
  input logic             reset,
  cond_counter_p_if.slave bus
);

  if (WIDTH < 2 || MAX < 1 || STEP < 1 || STEP > MAX ||
      (WIDTH < 31 && MAX > (1 << WIDTH) - 1)) begin : g_param_check
    $error("cond_counter_p: illegal WIDTH/MAX/STEP combination");
  end

  localparam logic [WIDTH:0]   MAX_X     = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_N     = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_N    = WIDTH'(STEP);
  // MAX+1 may equal 2^WIDTH and truncate to 0; wrap results are exact in WIDTH bits anyway.
  localparam logic [WIDTH-1:0] MODULUS_N = WIDTH'(MAX + 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             bflag_q, bflag_d;
  logic             dir_q, dir_d;
  logic [WIDTH:0]   up_sum;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    bflag_d = bflag_q;
    dir_d   = dir_q;
    up_sum  = {1'b0, count_q} + STEP_X;
    if (bus.en) begin
      case (bus.S)
        2'd0: begin
          count_d = '0;
          bflag_d = 1'b0;
        end
        2'd1: begin
          dir_d = 1'b1;
          if (up_sum > MAX_X) begin
            tc_d    = 1'b1;
            bflag_d = 1'b1;
            count_d = (SATURATE != 0) ? MAX_N : count_q + STEP_N - MODULUS_N;
          end else begin
            count_d = count_q + STEP_N;
          end
        end
        2'd2: begin
          dir_d = 1'b0;
          if ({1'b0, count_q} < STEP_X) begin
            tc_d    = 1'b1;
            bflag_d = 1'b1;
            count_d = (SATURATE != 0) ? '0 : count_q + MODULUS_N - STEP_N;
          end else begin
            count_d = count_q - STEP_N;
          end
        end
        default: begin
          count_d = ({1'b0, bus.datain} > MAX_X) ? MAX_N : bus.datain;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      bflag_q <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      bflag_q <= bflag_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.dataout = count_q;
  assign bus.tc      = tc_q;
  assign bus.bflag   = bflag_q;
  assign bus.dir     = dir_q;

endmodule
